// File: rtl/fpu_issue_queue_if.sv
// rtl/fpu_issue_queue_if.sv - command, operand, result and response handshakes of the FP issue queue
interface fpu_issue_queue_if #(
    parameter int TAG_W = 4
);
    logic             cmd_val;
    logic             cmd_rdy;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [1:0]       cmd_sel;
    logic [TAG_W-1:0] cmd_tag;

    logic             fpu_opnd_val;
    logic             fpu_opnd_rdy;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [1:0]       fpu_sel;

    logic             fpu_res_val;
    logic [31:0]      fpu_res_bits;
    logic             fpu_res_rdy;

    logic             rsp_val;
    logic             rsp_rdy;
    logic [31:0]      rsp_bits;
    logic [TAG_W-1:0] rsp_tag;

    // Environment side: command producer, fpu_top and response consumer.
    modport master (
        output cmd_val, cmd_a, cmd_b, cmd_sel, cmd_tag,
        input  cmd_rdy,
        input  fpu_opnd_val, fpu_a, fpu_b, fpu_sel,
        output fpu_opnd_rdy,
        output fpu_res_val, fpu_res_bits,
        input  fpu_res_rdy,
        input  rsp_val, rsp_bits, rsp_tag,
        output rsp_rdy
    );

    modport slave (
        input  cmd_val, cmd_a, cmd_b, cmd_sel, cmd_tag,
        output cmd_rdy,
        output fpu_opnd_val, fpu_a, fpu_b, fpu_sel,
        input  fpu_opnd_rdy,
        input  fpu_res_val, fpu_res_bits,
        output fpu_res_rdy,
        output rsp_val, rsp_bits, rsp_tag,
        input  rsp_rdy
    );
endinterface

// File: rtl/fpu_issue_queue.sv
// rtl/fpu_issue_queue.sv - tagged FP command FIFO feeding fpu_top, one op in flight, held tagged response
module fpu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    fpu_issue_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     err_stray
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       sel;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_val_q, rsp_val_d;
    logic [31:0]      rsp_bits_q, rsp_bits_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             err_stray_q, err_stray_d;

    logic cmd_rdy_w, opnd_val_w, res_rdy_w;
    logic push, pop, capture, drain;

    assign cmd_rdy_w  = (count_q != CW'(DEPTH));
    assign opnd_val_w = (count_q != '0) && !inflight_q;
    // Response register is guaranteed empty when fpu_top's pulse lands.
    assign res_rdy_w  = inflight_q && !rsp_val_q;

    assign push    = bus.cmd_val && cmd_rdy_w;
    assign pop     = opnd_val_w && bus.fpu_opnd_rdy;
    assign capture = bus.fpu_res_val && inflight_q;
    assign drain   = rsp_val_q && bus.rsp_rdy;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        inflight_d  = inflight_q;
        tag_d       = tag_q;
        rsp_val_d   = rsp_val_q;
        rsp_bits_d  = rsp_bits_q;
        rsp_tag_d   = rsp_tag_q;
        err_stray_d = err_stray_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel, tag: bus.cmd_tag};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            inflight_d = 1'b1;
            tag_d      = mem_q[rd_ptr_q].tag;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (capture) begin
            inflight_d = 1'b0;
            rsp_val_d  = 1'b1;
            rsp_bits_d = bus.fpu_res_bits;
            rsp_tag_d  = tag_q;
        end else if (drain) begin
            rsp_val_d  = 1'b0;
        end

        // A result with nothing outstanding is dropped and flagged.
        if (bus.fpu_res_val && !inflight_q) begin
            err_stray_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
            rsp_val_q   <= 1'b0;
            rsp_bits_q  <= '0;
            rsp_tag_q   <= '0;
            err_stray_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            rsp_val_q   <= rsp_val_d;
            rsp_bits_q  <= rsp_bits_d;
            rsp_tag_q   <= rsp_tag_d;
            err_stray_q <= err_stray_d;
        end
    end

    assign bus.cmd_rdy      = cmd_rdy_w;
    assign bus.fpu_opnd_val = opnd_val_w;
    assign bus.fpu_a        = mem_q[rd_ptr_q].a;
    assign bus.fpu_b        = mem_q[rd_ptr_q].b;
    assign bus.fpu_sel      = mem_q[rd_ptr_q].sel;
    assign bus.fpu_res_rdy  = res_rdy_w;
    assign bus.rsp_val      = rsp_val_q;
    assign bus.rsp_bits     = rsp_bits_q;
    assign bus.rsp_tag      = rsp_tag_q;

    assign count     = count_q;
    assign busy      = (count_q != '0) || inflight_q || rsp_val_q;
    assign err_stray = err_stray_q;
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb/tb_fpu_issue_queue.sv - bench for fpu_issue_queue with an fpu_top stand-in and in-order response model
module tb_fpu_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       sel;
        logic [TAG_W-1:0] tag;
    } cmd_s;

    typedef struct {
        logic [31:0]      bits;
        logic [TAG_W-1:0] tag;
    } rsp_s;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [$clog2(DEPTH):0] count;
    logic                   busy;
    logic                   err_stray;

    fpu_issue_queue_if #(.TAG_W(TAG_W)) bus ();

    fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .count     (count),
        .busy      (busy),
        .err_stray (err_stray)
    );

    int   total = 0;
    int   bad = 0;
    cmd_s cmd_q[$];
    rsp_s exp_q[$];
    int   sent = 0;
    int   rcv = 0;
    int   rsp_mode = 0;
    bit   stall_mode = 1'b0;
    bit   opnd_hold = 1'b0;
    int   stray_req = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Stand-in for fpu_top's arithmetic: real IEEE results for the directed cases, a mixing function otherwise.
    function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
        if (a == 32'h3F800000 && b == 32'h40000000 && sel == 2'b00) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'h3F800000 && sel == 2'b01) return 32'h40000000;
        if (a == 32'h40000000 && b == 32'h40400000 && sel == 2'b10) return 32'h40C00000;
        return a ^ {b[30:0], b[31]} ^ {30'd0, sel};
    endfunction

    // fpu_top model: accepts an operand, waits to see result_rdy at an edge, then pulses result_val one cycle.
    initial begin
        logic        fire;
        logic        fbusy;
        logic [31:0] res;
        int          stray_done;
        cmd_s        c;
        fire = 1'b0; fbusy = 1'b0; res = '0; stray_done = 0;
        bus.fpu_opnd_rdy = 1'b0;
        bus.fpu_res_val  = 1'b0;
        bus.fpu_res_bits = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                fire = 1'b0; fbusy = 1'b0; stray_done = stray_req;
                bus.fpu_res_val  = 1'b0;
                bus.fpu_opnd_rdy = 1'b0;
                continue;
            end
            bus.fpu_res_val = 1'b0;
            if (fire) begin
                bus.fpu_res_val  = 1'b1;
                bus.fpu_res_bits = res;
                fire  = 1'b0;
                fbusy = 1'b0;
            end else if (stray_req != stray_done && !fbusy) begin
                bus.fpu_res_val  = 1'b1;
                bus.fpu_res_bits = $urandom;
                stray_done = stray_req;
            end
            if (fbusy && bus.fpu_res_rdy) fire = 1'b1;
            bus.fpu_opnd_rdy = !opnd_hold && (!stall_mode || $urandom_range(0, 3) != 0);
            if (bus.fpu_opnd_val && bus.fpu_opnd_rdy) begin
                chk("single_inflight", 64'(fbusy), 64'd0);
                chk("issue_has_cmd", 64'(cmd_q.size() != 0), 64'd1);
                if (cmd_q.size() != 0) begin
                    c = cmd_q.pop_front();
                    chk("issue_a", bus.fpu_a, c.a);
                    chk("issue_b", bus.fpu_b, c.b);
                    chk("issue_sel", bus.fpu_sel, c.sel);
                    res = calc(c.a, c.b, c.sel);
                    exp_q.push_back('{res, c.tag});
                end
                fbusy = 1'b1;
            end
        end
    end

    // Response consumer: rsp_mode 0 stalls, 1 always ready, 2 random; every accepted response checked in order.
    initial begin
        rsp_s e;
        bus.rsp_rdy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                bus.rsp_rdy = 1'b0;
                continue;
            end
            case (rsp_mode)
                0:       bus.rsp_rdy = 1'b0;
                1:       bus.rsp_rdy = 1'b1;
                default: bus.rsp_rdy = 1'($urandom_range(0, 1));
            endcase
            if (bus.rsp_val && bus.rsp_rdy) begin
                chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_bits_order", bus.rsp_bits, e.bits);
                    chk("rsp_tag_order", bus.rsp_tag, e.tag);
                end
                rcv++;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel, input logic [TAG_W-1:0] tag);
        int n = 0;
        bus.cmd_val = 1'b1;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = sel; bus.cmd_tag = tag;
        while (!bus.cmd_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 64'(bus.cmd_rdy), 64'd1);
        if (bus.cmd_rdy) begin
            cmd_q.push_back('{a, b, sel, tag});
            sent++;
        end
        @(negedge clk);
        bus.cmd_val = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.rsp_val && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(bus.rsp_val), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || cmd_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 64'(n < 2000), 64'd1);
    endtask

    initial begin
        bus.cmd_val = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0; bus.cmd_tag = '0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
        chk("rst_opnd_val", 64'(bus.fpu_opnd_val), 64'd0);
        chk("rst_rsp_val", 64'(bus.rsp_val), 64'd0);
        chk("rst_rsp_bits", bus.rsp_bits, 64'd0);
        chk("rst_rsp_tag", bus.rsp_tag, 64'd0);
        chk("rst_count", count, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_stray), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);

        // Single add.
        rsp_mode = 1;
        send(32'h3F800000, 32'h40000000, 2'b00, 4'd5);
        chk("add_issue_next", 64'(bus.fpu_opnd_val), 64'd1);
        wait_rsp("add_rsp_seen");
        chk("add_bits", bus.rsp_bits, 64'h40400000);
        chk("add_tag", bus.rsp_tag, 64'd5);
        wait_idle();

        // Back-to-back ordering.
        send(32'h40400000, 32'h3F800000, 2'b01, 4'd1);
        send(32'h40000000, 32'h40400000, 2'b10, 4'd2);
        wait_rsp("b2b_rsp1_seen");
        chk("b2b_bits1", bus.rsp_bits, 64'h40000000);
        chk("b2b_tag1", bus.rsp_tag, 64'd1);
        wait_rsp("b2b_rsp2_seen");
        chk("b2b_bits2", bus.rsp_bits, 64'h40C00000);
        chk("b2b_tag2", bus.rsp_tag, 64'd2);
        wait_idle();

        // Fill: one response held, one in flight, DEPTH queued, then an extra push is refused.
        rsp_mode = 0;
        for (int i = 0; i < DEPTH + 2; i++) send($urandom, $urandom, 2'($urandom_range(0, 3)), 4'(i + 8));
        repeat (4) @(negedge clk);
        chk("full_count", count, DEPTH);
        chk("full_cmd_rdy", 64'(bus.cmd_rdy), 64'd0);
        chk("full_rsp_val", 64'(bus.rsp_val), 64'd1);
        chk("full_res_rdy", 64'(bus.fpu_res_rdy), 64'd0);
        bus.cmd_val = 1'b1; bus.cmd_tag = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("extra_push_count", count, DEPTH);
            chk("extra_push_rdy", 64'(bus.cmd_rdy), 64'd0);
        end
        bus.cmd_val = 1'b0;
        rsp_mode = 1;
        wait_idle();
        chk("full_drained", rcv, sent);

        // Simultaneous push and pop at count 2.
        opnd_hold = 1'b1;
        @(negedge clk);
        send(32'h11111111, 32'h22222222, 2'b11, 4'd3);
        send(32'h33333333, 32'h44444444, 2'b00, 4'd4);
        chk("pp_count_before", count, 64'd2);
        bus.cmd_val = 1'b1;
        bus.cmd_a = 32'h55555555; bus.cmd_b = 32'h66666666; bus.cmd_sel = 2'b01; bus.cmd_tag = 4'd6;
        cmd_q.push_back('{32'h55555555, 32'h66666666, 2'b01, 4'd6});
        sent++;
        opnd_hold = 1'b0;
        @(negedge clk);
        bus.cmd_val = 1'b0;
        chk("pp_count_after", count, 64'd2);
        chk("pp_count_model", count, cmd_q.size());
        wait_idle();

        // Random traffic well past several pointer wraps.
        stall_mode = 1'b1;
        rsp_mode   = 2;
        for (int i = 0; i < 3 * DEPTH + 20; i++) begin
            send($urandom, $urandom, 2'($urandom_range(0, 3)), 4'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rand_count_model", count, cmd_q.size());
            end
        end
        wait_idle();
        chk("rand_all_rcv", rcv, sent);
        chk("rand_exp_empty", exp_q.size(), 64'd0);
        chk("no_stray_yet", 64'(err_stray), 64'd0);

        // Reset with one in flight and three queued.
        stall_mode = 1'b0;
        rsp_mode   = 0;
        send($urandom, $urandom, 2'b00, 4'd1);
        send($urandom, $urandom, 2'b01, 4'd2);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 2'b10, 4'(i + 3));
        chk("mid_count", count, 64'd3);
        chk("mid_rsp_val", 64'(bus.rsp_val), 64'd1);
        reset = 1'b0;
        cmd_q.delete();
        exp_q.delete();
        #1;
        chk("mid_rst_count", count, 64'd0);
        chk("mid_rst_rsp_val", 64'(bus.rsp_val), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
        chk("mid_rst_res_rdy", 64'(bus.fpu_res_rdy), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rsp_mode = 1;
        repeat (5) begin
            @(negedge clk);
            chk("post_mid_no_rsp", 64'(bus.rsp_val), 64'd0);
        end

        // Stray result pulse with nothing in flight.
        chk("pre_stray_err", 64'(err_stray), 64'd0);
        stray_req++;
        repeat (3) @(negedge clk);
        chk("stray_err", 64'(err_stray), 64'd1);
        chk("stray_no_rsp", 64'(bus.rsp_val), 64'd0);
        chk("stray_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        chk("stray_sticky", 64'(err_stray), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
